// File: rtl/synth_pkg.sv
// Shared types, widths and the saturating adder used by the voice bank.
package synth_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    APPLY  = 2'd2
  } voice_fsm_e;

  localparam int RATE_WIDTH = 24;
  localparam int NOTE_WIDTH = 7;
  localparam int ACC_WIDTH  = 32;

  // Adds two accumulator values and clamps the result to a signed sw-bit range.
  function automatic logic signed [ACC_WIDTH-1:0] sat_add(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [ACC_WIDTH-1:0] b,
    input int unsigned                 sw
  );
    logic signed [ACC_WIDTH:0] sum;
    logic signed [ACC_WIDTH:0] hi;
    logic signed [ACC_WIDTH:0] lo;
    sum = 33'(a) + 33'(b);
    hi  = (33'sd1 <<< (sw - 32'd1)) - 33'sd1;
    lo  = -hi - 33'sd1;
    if (sum > hi) begin
      sat_add = hi[ACC_WIDTH-1:0];
    end else if (sum < lo) begin
      sat_add = lo[ACC_WIDTH-1:0];
    end else begin
      sat_add = sum[ACC_WIDTH-1:0];
    end
  endfunction

endpackage

// File: rtl/phase_counter.sv
// Per-voice sample index generator: advances the index once every max(rate,1)
// cycles and wraps at max(wave_width,1).
module phase_counter #(
  parameter int WW_WIDTH = 18,
  parameter int RATE_W   = synth_pkg::RATE_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                active,
  input  logic                restart,
  input  logic                width_update,
  input  logic [RATE_W-1:0]   rate,
  input  logic [WW_WIDTH-1:0] wave_width,
  output logic [WW_WIDTH-1:0] index
);
  import synth_pkg::*;

  logic [RATE_W-1:0]   cnt_r;
  logic [RATE_W-1:0]   rate_lim_s;
  logic [WW_WIDTH-1:0] index_r;
  logic [WW_WIDTH-1:0] width_lim_s;

  // Last count / last index before wrap, treating zero as one.
  always_comb begin
    rate_lim_s  = (rate == '0) ? '0 : rate - RATE_W'(1'b1);
    width_lim_s = (wave_width == '0) ? '0 : wave_width - WW_WIDTH'(1'b1);
  end

  // Idle, restarted and width-updated voices sit at index 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r   <= '0;
      index_r <= '0;
    end else if (restart || width_update || !active) begin
      cnt_r   <= '0;
      index_r <= '0;
    end else if (cnt_r >= rate_lim_s) begin
      cnt_r   <= '0;
      index_r <= (index_r >= width_lim_s) ? '0 : index_r + WW_WIDTH'(1'b1);
    end else begin
      cnt_r   <= cnt_r + RATE_W'(1'b1);
    end
  end

  assign index = index_r;

endmodule

// File: rtl/voice_bank.sv
// Polyphonic voice bank: note-to-voice allocation, per-voice phase counters
// and a saturating mixer of the samples returned by the wave loader.
module voice_bank #(
  parameter int NUM_VOICES   = 4,
  parameter int WW_WIDTH     = 18,
  parameter int SAMPLE_WIDTH = 16,
  parameter int RATE_WIDTH   = synth_pkg::RATE_WIDTH,
  parameter int NOTE_WIDTH   = synth_pkg::NOTE_WIDTH,
  parameter int READ_LATENCY = 2
) (
  input  logic                                     clk_in,
  input  logic                                     rst_in,
  input  logic                                     note_valid_in,
  output logic                                     note_ready_out,
  input  logic                                     note_on_in,
  input  logic [NOTE_WIDTH-1:0]                    note_num_in,
  input  logic [RATE_WIDTH-1:0]                    rate_in,
  input  logic [WW_WIDTH-1:0]                      wave_width_in,
  input  logic                                     width_update_in,
  output logic [NUM_VOICES-1:0][WW_WIDTH-1:0]      sample_index_out,
  input  logic [NUM_VOICES-1:0][SAMPLE_WIDTH-1:0]  sample_data_in,
  output logic [NUM_VOICES-1:0]                    voice_active_out,
  output logic [SAMPLE_WIDTH-1:0]                  stream_out
);
  import synth_pkg::*;

  localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int SUM_W  = SAMPLE_WIDTH + $clog2(NUM_VOICES);

  voice_fsm_e                  state_r, state_s;
  logic                        ready_r, accept_s;
  logic                        ev_on_r;
  logic [NOTE_WIDTH-1:0]       ev_note_r;
  logic [RATE_WIDTH-1:0]       ev_rate_r;
  logic [NUM_VOICES-1:0]       active_r, restart_s;
  logic [NOTE_WIDTH-1:0]       note_r [NUM_VOICES];
  logic [RATE_WIDTH-1:0]       rate_r [NUM_VOICES];
  logic [VIDX_W-1:0]           steal_r, match_idx_r, free_idx_r;
  logic [VIDX_W-1:0]           match_idx_s, free_idx_s, target_s;
  logic                        match_hit_r, free_hit_r, match_hit_s, free_hit_s;
  logic [NUM_VOICES-1:0]       act_dly_r [READ_LATENCY];
  logic signed [SUM_W-1:0]     sum_s;
  logic signed [ACC_WIDTH-1:0] mix_s;
  logic [SAMPLE_WIDTH-1:0]     stream_r;

  // Allocation FSM next state; an event is accepted only from IDLE.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (note_valid_in) begin
          state_s  = SEARCH;
          accept_s = 1'b1;
        end else begin
          state_s  = IDLE;
        end
      end
      SEARCH:  state_s = APPLY;
      APPLY:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // FSM state and registered ready flag.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_r <= IDLE;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_s;
      ready_r <= (state_s == IDLE);
    end
  end

  // Lowest matching active voice and lowest free voice (descending scan, lowest wins).
  always_comb begin
    match_hit_s = 1'b0;
    free_hit_s  = 1'b0;
    match_idx_s = '0;
    free_idx_s  = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      match_hit_s = (active_r[v] && note_r[v] == ev_note_r) ? 1'b1 : match_hit_s;
      match_idx_s = (active_r[v] && note_r[v] == ev_note_r) ? VIDX_W'(v) : match_idx_s;
      free_hit_s  = (!active_r[v]) ? 1'b1 : free_hit_s;
      free_idx_s  = (!active_r[v]) ? VIDX_W'(v) : free_idx_s;
    end
  end

  // Voice chosen in APPLY and the phase restart it triggers.
  always_comb begin
    restart_s = '0;
    if (match_hit_r) begin
      target_s = match_idx_r;
    end else if (free_hit_r) begin
      target_s = free_idx_r;
    end else begin
      target_s = steal_r;
    end
    if (state_r == APPLY && (ev_on_r || match_hit_r)) begin
      restart_s[target_s] = 1'b1;
    end else begin
      restart_s = '0;
    end
  end

  // Event latch, search results and the voice table.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      ev_on_r     <= 1'b0;
      ev_note_r   <= '0;
      ev_rate_r   <= '0;
      match_hit_r <= 1'b0;
      free_hit_r  <= 1'b0;
      match_idx_r <= '0;
      free_idx_r  <= '0;
      steal_r     <= '0;
      active_r    <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        note_r[v] <= '0;
        rate_r[v] <= '0;
      end
    end else begin
      if (accept_s) begin
        ev_on_r   <= note_on_in;
        ev_note_r <= note_num_in;
        ev_rate_r <= rate_in;
      end
      if (state_r == SEARCH) begin
        match_hit_r <= match_hit_s;
        match_idx_r <= match_idx_s;
        free_hit_r  <= free_hit_s;
        free_idx_r  <= free_idx_s;
      end
      if (state_r == APPLY && ev_on_r) begin
        active_r[target_s] <= 1'b1;
        note_r[target_s]   <= ev_note_r;
        rate_r[target_s]   <= ev_rate_r;
        if (!match_hit_r && !free_hit_r) begin
          steal_r <= (steal_r == VIDX_W'(NUM_VOICES - 1)) ? '0 : steal_r + VIDX_W'(1'b1);
        end
      end else if (state_r == APPLY && match_hit_r) begin
        active_r[match_idx_r] <= 1'b0;
      end
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    phase_counter #(
      .WW_WIDTH (WW_WIDTH),
      .RATE_W   (RATE_WIDTH)
    ) u_phase (
      .clk          (clk_in),
      .rst_n        (rst_in),
      .active       (active_r[v]),
      .restart      (restart_s[v]),
      .width_update (width_update_in),
      .rate         (rate_r[v]),
      .wave_width   (wave_width_in),
      .index        (sample_index_out[v])
    );
  end

  // Active mask delayed to line up with the loader's returned samples.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        act_dly_r[i] <= '0;
      end
    end else begin
      act_dly_r[0] <= active_r;
      for (int i = 1; i < READ_LATENCY; i++) begin
        act_dly_r[i] <= act_dly_r[i-1];
      end
    end
  end

  // Full-precision sum of aligned-active samples, clamped once at the end.
  always_comb begin
    sum_s = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      sum_s = sum_s + (act_dly_r[READ_LATENCY-1][v] ?
                       SUM_W'(signed'(sample_data_in[v])) : SUM_W'(1'b0));
    end
    mix_s = sat_add(ACC_WIDTH'(sum_s), 32'sd0, SAMPLE_WIDTH);
  end

  // Output stream register.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      stream_r <= '0;
    end else begin
      stream_r <= mix_s[SAMPLE_WIDTH-1:0];
    end
  end

  assign note_ready_out   = ready_r;
  assign voice_active_out = active_r;
  assign stream_out       = stream_r;

endmodule
